// File: rtl/ramcard_sram_ctrl.sv
// ----------------------------------------------------------------------------
// ramcard_sram_ctrl
//
// Memory-side responder between the 6502 bus / video generator and the board
// 512 KB asynchronous SRAM. Each source (CPU, video) owns a one-entry pending
// slot. A small FSM (IDLE -> SETUP -> STROBE -> DONE) runs fixed 3-cycle SRAM
// accesses, and video wins arbitration over the CPU.
//
// CPU addresses are resolved into a 19-bit SRAM address at capture time. The
// language-card state (ram_addr / card_ram_rd / card_ram_we) is sampled only
// at that moment. I/O-page accesses and writes to write-protected card space
// never reach the SRAM and are acknowledged on the following cycle.
//
// Ports
//   mclk28       in   28 MHz clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   cpu_req      in   one-cycle CPU request pulse
//   cpu_we       in   1 = write, 0 = read (sampled with cpu_req)
//   cpu_addr     in   16-bit CPU address
//   cpu_din      in   CPU write data
//   ram_addr     in   card-mapped 18-bit address
//   card_ram_rd  in   card RAM read-enable state
//   card_ram_we  in   card RAM write-enable state
//   vid_req      in   one-cycle video fetch pulse
//   vid_addr     in   video fetch address (main RAM)
//   cpu_dout     out  CPU read data, held until the next CPU read completes
//   cpu_ack      out  one-cycle CPU completion pulse
//   vid_dout     out  video read data, held until the next video read completes
//   vid_ack      out  one-cycle video completion pulse
//   overrun      out  one-cycle pulse: request to an already-pending source
//   sram_a       out  SRAM address
//   sram_dq      io   SRAM data bus
//   sram_we_n    out  SRAM write strobe, active low
//   sram_oe_n    out  SRAM output enable, active low
// ----------------------------------------------------------------------------
module ramcard_sram_ctrl (
  input  logic        mclk28,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic [17:0] ram_addr,
  input  logic        card_ram_rd,
  input  logic        card_ram_we,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic [7:0]  vid_dout,
  output logic        vid_ack,
  output logic        overrun,
  output logic [18:0] sram_a,
  inout  wire  [7:0]  sram_dq,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_VID = 1'b1;

  // FSM and current access
  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        acc_we_q, acc_we_d;

  // CPU pending slot
  logic        cpu_pend_q, cpu_pend_d;
  logic        cpu_we_q, cpu_we_d;
  logic [18:0] cpu_a_q, cpu_a_d;
  logic [7:0]  cpu_data_q, cpu_data_d;

  // Video pending slot
  logic        vid_pend_q, vid_pend_d;
  logic [15:0] vid_a_q, vid_a_d;

  // Registered outputs
  logic [18:0] sram_a_q, sram_a_d;
  logic        sram_we_n_q, sram_we_n_d;
  logic        sram_oe_n_q, sram_oe_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic [7:0]  dq_out_q, dq_out_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic [7:0]  vid_dout_q, vid_dout_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        vid_ack_q, vid_ack_d;
  logic        overrun_q, overrun_d;

  // --------------------------------------------------------------------------
  // CPU address resolution
  // --------------------------------------------------------------------------
  logic [18:0] cpu_res_a;
  logic        cpu_local;     // access handled without an SRAM cycle
  logic        cpu_hi_page;   // D000-FFFF

  assign cpu_hi_page = (cpu_addr[15:14] == 2'b11) && (cpu_addr[13:12] != 2'b00);

  always_comb begin
    cpu_res_a = {3'b000, cpu_addr};
    cpu_local = 1'b0;
    if (cpu_addr[15:12] == 4'hC) begin
      // I/O page: answered locally, reads float to FF
      cpu_local = 1'b1;
    end else if (cpu_hi_page) begin
      if (cpu_we) begin
        if (card_ram_we) begin
          cpu_res_a = {1'b1, ram_addr};
        end else begin
          // write-protected card space: discard
          cpu_local = 1'b1;
        end
      end else begin
        if (card_ram_rd) begin
          cpu_res_a = {1'b1, ram_addr};
        end else begin
          // ROM image lives at 0x10000 + cpu_addr
          cpu_res_a = {3'b001, cpu_addr};
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request capture
  // --------------------------------------------------------------------------
  // A slot that is in DONE is being released on this edge, so it can take a
  // fresh request without counting as an overrun.
  logic finishing;
  logic cpu_busy, vid_busy;
  logic cpu_take, cpu_cap_sram, cpu_cap_local, vid_cap;

  assign finishing     = (state_q == ST_DONE);
  assign cpu_busy      = cpu_pend_q & ~(finishing & (owner_q == OWN_CPU));
  assign vid_busy      = vid_pend_q & ~(finishing & (owner_q == OWN_VID));
  assign cpu_take      = cpu_req & ~cpu_busy;
  assign cpu_cap_sram  = cpu_take & ~cpu_local;
  assign cpu_cap_local = cpu_take &  cpu_local;
  assign vid_cap       = vid_req & ~vid_busy;

  always_comb begin
    cpu_pend_d = cpu_busy | cpu_cap_sram;
    cpu_we_d   = cpu_cap_sram ? cpu_we    : cpu_we_q;
    cpu_a_d    = cpu_cap_sram ? cpu_res_a : cpu_a_q;
    cpu_data_d = cpu_cap_sram ? cpu_din   : cpu_data_q;
    vid_pend_d = vid_busy | vid_cap;
    vid_a_d    = vid_cap ? vid_addr : vid_a_q;
  end

  // --------------------------------------------------------------------------
  // Arbitration and access sequencing
  // --------------------------------------------------------------------------
  // Ready includes requests arriving on this very edge, so an access can
  // start SETUP the cycle right after capture. Slot *_d values are used to
  // load the SRAM address for the same reason.
  logic vid_ready, cpu_ready, can_start, start, start_we;

  assign vid_ready = vid_busy | vid_cap;
  assign cpu_ready = cpu_busy | cpu_cap_sram;
  assign can_start = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start     = can_start & (vid_ready | cpu_ready);
  assign start_we  = vid_ready ? 1'b0 : cpu_we_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    acc_we_d    = acc_we_q;
    sram_a_d    = sram_a_q;
    sram_we_n_d = sram_we_n_q;
    sram_oe_n_d = sram_oe_n_q;
    dq_oe_d     = dq_oe_q;
    dq_out_d    = dq_out_q;
    cpu_dout_d  = cpu_dout_q;
    vid_dout_d  = vid_dout_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    overrun_d   = (cpu_req & cpu_busy) | (vid_req & vid_busy);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        sram_we_n_d = 1'b1;
        sram_oe_n_d = 1'b1;
        if (start) begin
          state_d     = ST_SETUP;
          owner_d     = vid_ready ? OWN_VID : OWN_CPU;
          acc_we_d    = start_we;
          sram_a_d    = vid_ready ? {3'b000, vid_a_d} : cpu_a_d;
          sram_oe_n_d = start_we;
          dq_oe_d     = start_we;
          dq_out_d    = cpu_data_d;
        end else begin
          state_d = ST_IDLE;
          dq_oe_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d     = ST_STROBE;
        sram_we_n_d = ~acc_we_q;
      end
      ST_STROBE: begin
        state_d     = ST_DONE;
        sram_we_n_d = 1'b1;
        sram_oe_n_d = 1'b1;
        if (!acc_we_q) begin
          if (owner_q == OWN_VID) begin
            vid_dout_d = sram_dq;
          end else begin
            cpu_dout_d = sram_dq;
          end
        end
        if (owner_q == OWN_VID) begin
          vid_ack_d = 1'b1;
        end else begin
          cpu_ack_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Local accesses cannot collide with a CPU SRAM completion: the CPU slot
    // is busy until its DONE cycle, which blocks capture.
    if (cpu_cap_local) begin
      cpu_ack_d = 1'b1;
      if (!cpu_we) begin
        cpu_dout_d = 8'hFF;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers. The asynchronous reset pulls sram_we_n high at once so a
  // write in progress is cut short without waiting for a clock edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge mclk28 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      acc_we_q    <= 1'b0;
      cpu_pend_q  <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_a_q     <= '0;
      cpu_data_q  <= '0;
      vid_pend_q  <= 1'b0;
      vid_a_q     <= '0;
      sram_a_q    <= '0;
      sram_we_n_q <= 1'b1;
      sram_oe_n_q <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
      cpu_dout_q  <= 8'hFF;
      vid_dout_q  <= 8'h00;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      acc_we_q    <= acc_we_d;
      cpu_pend_q  <= cpu_pend_d;
      cpu_we_q    <= cpu_we_d;
      cpu_a_q     <= cpu_a_d;
      cpu_data_q  <= cpu_data_d;
      vid_pend_q  <= vid_pend_d;
      vid_a_q     <= vid_a_d;
      sram_a_q    <= sram_a_d;
      sram_we_n_q <= sram_we_n_d;
      sram_oe_n_q <= sram_oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_dout_q  <= vid_dout_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sram_dq   = dq_oe_q ? dq_out_q : 8'hzz;
  assign sram_a    = sram_a_q;
  assign sram_we_n = sram_we_n_q;
  assign sram_oe_n = sram_oe_n_q;
  assign cpu_dout  = cpu_dout_q;
  assign vid_dout  = vid_dout_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_ack   = vid_ack_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ramcard_sram_ctrl.sv
// ----------------------------------------------------------------------------
// Self-checking bench for ramcard_sram_ctrl. A behavioural async SRAM model
// sits on the pins. Each test task pushes the acks it expects (source, data,
// cycle) onto a scoreboard queue; a negedge monitor collects what the DUT
// actually acknowledged, and the task pops and compares both.
// ----------------------------------------------------------------------------
module tb_ramcard_sram_ctrl;

  logic        mclk28 = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [17:0] ram_addr = '0;
  logic        card_ram_rd = 1'b0;
  logic        card_ram_we = 1'b0;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [7:0]  vid_dout;
  logic        vid_ack;
  logic        overrun;
  logic [18:0] sram_a;
  wire  [7:0]  sram_dq;
  logic        sram_we_n;
  logic        sram_oe_n;

  ramcard_sram_ctrl dut (
    .mclk28      (mclk28),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .ram_addr    (ram_addr),
    .card_ram_rd (card_ram_rd),
    .card_ram_we (card_ram_we),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .cpu_dout    (cpu_dout),
    .cpu_ack     (cpu_ack),
    .vid_dout    (vid_dout),
    .vid_ack     (vid_ack),
    .overrun     (overrun),
    .sram_a      (sram_a),
    .sram_dq     (sram_dq),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  always #5 mclk28 = ~mclk28;

  // --------------------------------------------------------------------------
  // Async SRAM model
  // --------------------------------------------------------------------------
  logic [7:0] mem [0:524287];

  function automatic logic [7:0] pat(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b00000, a[18:16]} ^ 8'hA5;
  endfunction

  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_a] : 8'hzz;

  always @(posedge mclk28) begin
    if (!sram_we_n) mem[sram_a] <= sram_dq;
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  typedef struct {
    bit         vid;
    logic [7:0] data;
    bit         chk;
    int         cyc;
  } ack_t;

  ack_t exp_q[$];
  ack_t obs_q[$];

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         we_cnt, oe_cnt, ovr_cnt, ovr_cyc;
  logic [18:0] we_addr, oe_addr;
  logic [7:0]  we_data;

  always @(posedge mclk28) cyc <= cyc + 1;

  always @(negedge mclk28) begin
    if (cpu_ack) obs_q.push_back('{vid: 1'b0, data: cpu_dout, chk: 1'b1, cyc: cyc});
    if (vid_ack) obs_q.push_back('{vid: 1'b1, data: vid_dout, chk: 1'b1, cyc: cyc});
    if (!sram_we_n) begin
      we_cnt++;
      we_addr = sram_a;
      we_data = sram_dq;
    end
    if (!sram_oe_n) begin
      oe_cnt++;
      oe_addr = sram_a;
    end
    if (overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
  end

  task automatic clear_mon();
    we_cnt = 0; oe_cnt = 0; ovr_cnt = 0; ovr_cyc = -1;
    we_addr = '0; oe_addr = '0; we_data = '0;
  endtask

  task automatic expect_ack(input bit vid, input logic [7:0] d, input bit chk, input int at);
    exp_q.push_back('{vid: vid, data: d, chk: chk, cyc: at});
  endtask

  // Drive one request cycle; cap is the cycle count right after the capture edge.
  task automatic drive_req(input bit do_cpu, input bit we, input logic [15:0] a,
                           input logic [7:0] d, input bit do_vid,
                           input logic [15:0] va, output int cap);
    @(negedge mclk28);
    cpu_req  = do_cpu;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
    vid_req  = do_vid;
    vid_addr = va;
    cap = cyc + 1;
    @(negedge mclk28);
    cpu_req = 1'b0;
    vid_req = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge mclk28);
    checks++;
    if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_a !== 19'h0) begin
      errors++;
      $display("FAIL reset_sram: got we_n=%b oe_n=%b a=%h, expected 1 1 00000", sram_we_n, sram_oe_n, sram_a);
    end
    checks++;
    if (cpu_dout !== 8'hFF || vid_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got cpu=%h vid=%h, expected ff 00", cpu_dout, vid_dout);
    end
    checks++;
    if (cpu_ack !== 1'b0 || vid_ack !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got cpu_ack=%b vid_ack=%b overrun=%b, expected 0 0 0", cpu_ack, vid_ack, overrun);
    end
    @(negedge mclk28);
    reset_n = 1'b1;
    repeat (2) @(negedge mclk28);
    $display("reset: sram_a=%h cpu_dout=%h vid_dout=%h", sram_a, cpu_dout, vid_dout);
  endtask

  task automatic test_main_rw();
    int cap;
    ack_t e, o;
    clear_mon();
    drive_req(1'b1, 1'b1, 16'h0400, 8'h5A, 1'b0, 16'h0, cap);
    expect_ack(1'b0, 8'h00, 1'b0, cap + 2);
    repeat (5) @(negedge mclk28);
    checks++;
    if (we_cnt != 1 || we_addr !== 19'h00400 || we_data !== 8'h5A) begin
      errors++;
      $display("FAIL main_write_strobe: got cnt=%0d a=%h d=%h, expected 1 00400 5a", we_cnt, we_addr, we_data);
    end
    clear_mon();
    drive_req(1'b1, 1'b0, 16'h0400, 8'h00, 1'b0, 16'h0, cap);
    expect_ack(1'b0, 8'h5A, 1'b1, cap + 2);
    repeat (5) @(negedge mclk28);
    checks++;
    if (oe_cnt != 2 || oe_addr !== 19'h00400 || we_cnt != 0) begin
      errors++;
      $display("FAIL main_read_oe: got oe_cnt=%0d a=%h we_cnt=%0d, expected 2 00400 0", oe_cnt, oe_addr, we_cnt);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL main_rw_ack: got none, expected vid=%0d cycle=%0d", e.vid, e.cyc);
      end else begin
        o = obs_q.pop_front();
        $display("main_rw: vid=%0d data=%h cycle=%0d", o.vid, o.data, o.cyc);
        if (o.vid != e.vid || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
          errors++;
          $display("FAIL main_rw_ack: got vid=%0d d=%h cyc=%0d, expected vid=%0d d=%h cyc=%0d", o.vid, o.data, o.cyc, e.vid, e.data, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL main_rw_extra: got %0d extra acks, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_rom_card();
    int cap;
    ack_t e, o;
    clear_mon();
    card_ram_rd = 1'b0;
    drive_req(1'b1, 1'b0, 16'hE000, 8'h00, 1'b0, 16'h0, cap);
    expect_ack(1'b0, pat(19'h1E000), 1'b1, cap + 2);
    repeat (5) @(negedge mclk28);
    checks++;
    if (oe_addr !== 19'h1E000) begin
      errors++;
      $display("FAIL rom_addr: got %h, expected 1e000", oe_addr);
    end
    clear_mon();
    card_ram_rd = 1'b1;
    ram_addr = 18'h0E000;
    drive_req(1'b1, 1'b0, 16'hE000, 8'h00, 1'b0, 16'h0, cap);
    // Soft switches move after capture; the access must not follow them.
    card_ram_rd = 1'b0;
    ram_addr = 18'h12345;
    expect_ack(1'b0, pat(19'h4E000), 1'b1, cap + 2);
    repeat (5) @(negedge mclk28);
    checks++;
    if (oe_addr !== 19'h4E000) begin
      errors++;
      $display("FAIL card_addr: got %h, expected 4e000", oe_addr);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL rom_card_ack: got none, expected vid=%0d cycle=%0d", e.vid, e.cyc);
      end else begin
        o = obs_q.pop_front();
        $display("rom_card: vid=%0d data=%h cycle=%0d", o.vid, o.data, o.cyc);
        if (o.vid != e.vid || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
          errors++;
          $display("FAIL rom_card_ack: got vid=%0d d=%h cyc=%0d, expected vid=%0d d=%h cyc=%0d", o.vid, o.data, o.cyc, e.vid, e.data, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rom_card_extra: got %0d extra acks, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_discard();
    int cap;
    ack_t e, o;
    clear_mon();
    card_ram_we = 1'b0;
    drive_req(1'b1, 1'b1, 16'hD000, 8'h99, 1'b0, 16'h0, cap);
    expect_ack(1'b0, 8'h00, 1'b0, cap);
    repeat (5) @(negedge mclk28);
    checks++;
    if (we_cnt != 0 || oe_cnt != 0) begin
      errors++;
      $display("FAIL discard_strobe: got we_cnt=%0d oe_cnt=%0d, expected 0 0", we_cnt, oe_cnt);
    end
    clear_mon();
    card_ram_we = 1'b1;
    ram_addr = 18'h2D000;
    drive_req(1'b1, 1'b1, 16'hD000, 8'h3C, 1'b0, 16'h0, cap);
    card_ram_we = 1'b0;
    expect_ack(1'b0, 8'h00, 1'b0, cap + 2);
    repeat (5) @(negedge mclk28);
    checks++;
    if (we_cnt != 1 || we_addr !== 19'h6D000 || we_data !== 8'h3C) begin
      errors++;
      $display("FAIL card_write: got cnt=%0d a=%h d=%h, expected 1 6d000 3c", we_cnt, we_addr, we_data);
    end
    card_ram_rd = 1'b1;
    ram_addr = 18'h2D000;
    drive_req(1'b1, 1'b0, 16'hD000, 8'h00, 1'b0, 16'h0, cap);
    card_ram_rd = 1'b0;
    expect_ack(1'b0, 8'h3C, 1'b1, cap + 2);
    repeat (5) @(negedge mclk28);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL discard_ack: got none, expected vid=%0d cycle=%0d", e.vid, e.cyc);
      end else begin
        o = obs_q.pop_front();
        $display("discard: vid=%0d data=%h cycle=%0d", o.vid, o.data, o.cyc);
        if (o.vid != e.vid || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
          errors++;
          $display("FAIL discard_ack: got vid=%0d d=%h cyc=%0d, expected vid=%0d d=%h cyc=%0d", o.vid, o.data, o.cyc, e.vid, e.data, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL discard_extra: got %0d extra acks, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_io_page();
    int cap;
    ack_t e, o;
    clear_mon();
    drive_req(1'b1, 1'b0, 16'hC030, 8'h00, 1'b0, 16'h0, cap);
    expect_ack(1'b0, 8'hFF, 1'b1, cap);
    repeat (4) @(negedge mclk28);
    drive_req(1'b1, 1'b1, 16'hC030, 8'h42, 1'b0, 16'h0, cap);
    expect_ack(1'b0, 8'h00, 1'b0, cap);
    repeat (4) @(negedge mclk28);
    checks++;
    if (oe_cnt != 0 || we_cnt != 0) begin
      errors++;
      $display("FAIL io_strobe: got oe_cnt=%0d we_cnt=%0d, expected 0 0", oe_cnt, we_cnt);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL io_ack: got none, expected vid=%0d cycle=%0d", e.vid, e.cyc);
      end else begin
        o = obs_q.pop_front();
        $display("io_page: vid=%0d data=%h cycle=%0d", o.vid, o.data, o.cyc);
        if (o.vid != e.vid || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
          errors++;
          $display("FAIL io_ack: got vid=%0d d=%h cyc=%0d, expected vid=%0d d=%h cyc=%0d", o.vid, o.data, o.cyc, e.vid, e.data, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL io_extra: got %0d extra acks, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_collision();
    int cap;
    ack_t e, o;
    clear_mon();
    // Same edge: video served first, CPU behind it.
    drive_req(1'b1, 1'b0, 16'h0400, 8'h00, 1'b1, 16'h2000, cap);
    expect_ack(1'b1, pat(19'h02000), 1'b1, cap + 2);
    expect_ack(1'b0, 8'h5A, 1'b1, cap + 5);
    repeat (8) @(negedge mclk28);
    // Back-to-back: video at N, CPU at N+1, CPU starts right after video DONE.
    @(negedge mclk28);
    vid_req = 1'b1; vid_addr = 16'h2100;
    cap = cyc + 1;
    @(negedge mclk28);
    vid_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    @(negedge mclk28);
    cpu_req = 1'b0;
    expect_ack(1'b1, pat(19'h02100), 1'b1, cap + 2);
    expect_ack(1'b0, 8'h5A, 1'b1, cap + 5);
    repeat (8) @(negedge mclk28);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL collision_ack: got none, expected vid=%0d cycle=%0d", e.vid, e.cyc);
      end else begin
        o = obs_q.pop_front();
        $display("collision: vid=%0d data=%h cycle=%0d", o.vid, o.data, o.cyc);
        if (o.vid != e.vid || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
          errors++;
          $display("FAIL collision_ack: got vid=%0d d=%h cyc=%0d, expected vid=%0d d=%h cyc=%0d", o.vid, o.data, o.cyc, e.vid, e.data, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL collision_extra: got %0d extra acks, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_overrun();
    int cap, cap_v;
    ack_t e, o;
    clear_mon();
    @(negedge mclk28);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0500; cpu_din = 8'h11;
    cap = cyc + 1;
    @(negedge mclk28);
    cpu_din = 8'h22;            // second pulse while the first is pending
    @(negedge mclk28);
    cpu_req = 1'b0;
    expect_ack(1'b0, 8'h00, 1'b0, cap + 2);
    repeat (5) @(negedge mclk28);
    checks++;
    if (ovr_cnt != 1 || ovr_cyc != cap + 1) begin
      errors++;
      $display("FAIL cpu_overrun: got cnt=%0d cyc=%0d, expected 1 %0d", ovr_cnt, ovr_cyc, cap + 1);
    end
    checks++;
    if (we_cnt != 1 || we_data !== 8'h11) begin
      errors++;
      $display("FAIL overrun_keep: got cnt=%0d d=%h, expected 1 11", we_cnt, we_data);
    end
    clear_mon();
    @(negedge mclk28);
    vid_req = 1'b1; vid_addr = 16'h0500;
    cap_v = cyc + 1;
    @(negedge mclk28);
    vid_addr = 16'h3000;
    @(negedge mclk28);
    vid_req = 1'b0;
    expect_ack(1'b1, 8'h11, 1'b1, cap_v + 2);
    repeat (5) @(negedge mclk28);
    checks++;
    if (ovr_cnt != 1 || ovr_cyc != cap_v + 1) begin
      errors++;
      $display("FAIL vid_overrun: got cnt=%0d cyc=%0d, expected 1 %0d", ovr_cnt, ovr_cyc, cap_v + 1);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL overrun_ack: got none, expected vid=%0d cycle=%0d", e.vid, e.cyc);
      end else begin
        o = obs_q.pop_front();
        $display("overrun: vid=%0d data=%h cycle=%0d", o.vid, o.data, o.cyc);
        if (o.vid != e.vid || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
          errors++;
          $display("FAIL overrun_ack: got vid=%0d d=%h cyc=%0d, expected vid=%0d d=%h cyc=%0d", o.vid, o.data, o.cyc, e.vid, e.data, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_extra: got %0d extra acks, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_write();
    int cap;
    clear_mon();
    drive_req(1'b1, 1'b1, 16'h0600, 8'h77, 1'b0, 16'h0, cap);
    @(negedge mclk28);          // STROBE cycle
    checks++;
    if (sram_we_n !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_strobe: got we_n=%b, expected 0", sram_we_n);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (sram_we_n !== 1'b1) begin
      errors++;
      $display("FAIL midwrite_async: got we_n=%b, expected 1", sram_we_n);
    end
    repeat (4) @(negedge mclk28);
    checks++;
    if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_a !== 19'h0 ||
        cpu_dout !== 8'hFF || vid_dout !== 8'h00 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_reset_vals: got we_n=%b oe_n=%b a=%h cpu=%h vid=%h ovr=%b, expected 1 1 00000 ff 00 0",
               sram_we_n, sram_oe_n, sram_a, cpu_dout, vid_dout, overrun);
    end
    reset_n = 1'b1;
    repeat (6) @(negedge mclk28);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL midwrite_ack: got %0d acks, expected 0", obs_q.size());
      obs_q.delete();
    end
    checks++;
    if (mem[19'h00600] !== pat(19'h00600)) begin
      errors++;
      $display("FAIL midwrite_mem: got %h, expected %h", mem[19'h00600], pat(19'h00600));
    end
    $display("reset_mid_write: we_n=%b cpu_dout=%h", sram_we_n, cpu_dout);
  endtask

  initial begin
    for (int i = 0; i < 524288; i++) mem[i] = pat(i[18:0]);
    clear_mon();
    test_reset();
    test_main_rw();
    test_rom_card();
    test_discard();
    test_io_page();
    test_collision();
    test_overrun();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ramcard_sram_ctrl.md
# ramcard_sram_ctrl

Memory-side responder for the language-card / Saturn mapping logic. Accepts CPU and video fetch requests, resolves the final physical address from the CPU address and the card's `ram_addr` / `card_ram_rd` / `card_ram_we` outputs, and runs fixed 3-cycle accesses on the external 512 KB asynchronous SRAM. It sits between the 6502 bus / video generator and the board SRAM pins, in the `mclk28` domain.

## Interface
- No parameters.
- `mclk28` in 1: 28 MHz system clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: one-cycle pulse; CPU address, data and direction valid.
- `cpu_we` in 1: 1 = write, 0 = read; sampled with `cpu_req`.
- `cpu_addr` in 16: CPU address.
- `cpu_din` in 8: CPU write data.
- `ram_addr` in 18: card-mapped address from the mapping block.
- `card_ram_rd` in 1: card RAM read-enable state.
- `card_ram_we` in 1: card RAM write-enable state.
- `vid_req` in 1: one-cycle pulse; video fetch request.
- `vid_addr` in 16: video fetch address; always main RAM.
- `cpu_dout` out 8: CPU read data; held until the next CPU read completes.
- `cpu_ack` out 1: one-cycle pulse; CPU access complete.
- `vid_dout` out 8: video read data; held until the next video read completes.
- `vid_ack` out 1: one-cycle pulse; video access complete.
- `overrun` out 1: one-cycle pulse; a request arrived while the same source was already pending.
- `sram_a` out 19: SRAM address.
- `sram_dq` inout 8: SRAM data.
- `sram_we_n` out 1: SRAM write strobe, active low.
- `sram_oe_n` out 1: SRAM output enable, active low.

## Operation
- **Request capture.** Each source has a one-entry pending slot.
  - Requests are captured at the edge where the `*_req` pulse is high.
  - For CPU requests, the resolved address, direction and data are latched at that edge.
  - A request to an already-pending source is dropped and pulses `overrun`; the original request is kept.
- **CPU address resolution** (at capture):
  - `cpu_addr` 0000–BFFF: `sram_a = {3'b000, cpu_addr}`.
  - C000–CFFF: no SRAM cycle. `cpu_ack` pulses the cycle after capture, and `cpu_dout` is set to 8'hFF on reads.
  - D000–FFFF read with `card_ram_rd`=1: `sram_a = {1'b1, ram_addr}`.
  - D000–FFFF read with `card_ram_rd`=0: ROM, `sram_a = {3'b001, cpu_addr}`.
  - D000–FFFF write with `card_ram_we`=1: `sram_a = {1'b1, ram_addr}`.
  - D000–FFFF write with `card_ram_we`=0: the write is discarded. No SRAM cycle; `cpu_ack` pulses the cycle after capture.
- **Video address:** `sram_a = {3'b000, vid_addr}`.
- **FSM states:** IDLE, SETUP, STROBE, DONE. The current owner (CPU or VID) is registered on entry to SETUP.
  - IDLE → SETUP when any request is pending or arriving. Video has priority over CPU when both are present.
  - SETUP: `sram_a` is driven.
    - Read: `sram_oe_n`=0.
    - Write: `sram_dq` is driven with data, and stays driven through DONE.
  - STROBE:
    - Write: `sram_we_n`=0, this state only.
    - Read: `sram_oe_n` stays 0, and `sram_dq` is registered at the edge leaving STROBE.
  - DONE: strobes are inactive and the owner's ack is high. The read result appears on `cpu_dout` or `vid_dout`.
    - DONE → SETUP if another request is pending (video first), else → IDLE.
- **Bus idle state:** outside write ownership `sram_dq` is high-Z. `sram_oe_n`=1 except during read SETUP/STROBE.

## Timing
- **Reset values:**
  - `sram_we_n`=1, `sram_oe_n`=1, `sram_dq` high-Z, `sram_a`=0.
  - `cpu_dout`=8'hFF, `vid_dout`=8'h00.
  - Acks and `overrun` = 0; pending slots cleared; FSM in IDLE.
- **Reset mid-access:** asserting `reset_n` low forces `sram_we_n` high immediately (asynchronously). The access is abandoned and no ack is produced.
- **Latency:** for a request captured at edge N in IDLE, the ack is high during cycle N+3 (SETUP N+1, STROBE N+2, DONE N+3).
- **Back-to-back:** a second pending request starts SETUP the cycle after DONE, i.e. 3-cycle throughput.
- **Worst-case CPU latency:** 6 cycles when a video access is simultaneous, well inside one 1 MHz CPU cycle (28 clocks).
- **Simultaneous requests:** CPU and video requests on the same edge are both captured; video is served first.
- **Capture timing:** `card_ram_rd` / `card_ram_we` / `ram_addr` are sampled only at CPU capture. Later soft-switch changes do not affect an in-flight access.
- **Address width:** `{1'b1, ram_addr}` spans 0x40000–0x7FFFF.

## Test plan
- **Main RAM read/write:** write 8'h5A at 0x0400, then read 0x0400. Expect `sram_a`=0x00400 and `sram_we_n` low exactly 1 cycle. `cpu_ack` arrives at N+3 with `cpu_dout`=8'h5A.
- **ROM vs card:** read 0xE000 with `card_ram_rd`=0, expect `sram_a`=0x0E000+0x10000 (0x1E000). Then with `card_ram_rd`=1 and `ram_addr`=0x0E000, expect `sram_a`=0x4E000.
- **Discarded write:** write 0xD000 with `card_ram_we`=0. Expect no SRAM strobe and `cpu_ack` at N+1. Repeat with `card_ram_we`=1 and `ram_addr`=0x2D000: expect `sram_a`=0x6D000 and a write strobe.
- **I/O page:** read 0xC030. Expect no `sram_oe_n` activity, `cpu_ack` at N+1, `cpu_dout`=8'hFF.
- **Collision and priority:**
  - `cpu_req` and `vid_req` on the same edge: `vid_ack` at N+3, `cpu_ack` at N+6.
  - A second `cpu_req` at N+1 pulses `overrun` and keeps the first request's data.
- **Reset mid-write:** drop `reset_n` during STROBE. `sram_we_n` returns to 1 before the next edge, no ack follows, and all outputs hold their reset values.
